ldm_stm_sequencer: RTL and testbench

- Multi-cycle controller that runs ARMv7 block transfers (LDM/STM, all four addressing modes) by stepping through a 16-bit register list.
- Per transferred register it drives one read port (STM) or the write port (LDM) of the 15-entry register file, plus one data-memory access.
- Optionally writes back the updated base register at the end.
- Sits between decode/control and the register file / data-memory interface; the core stalls while `o_Busy` is high.

---
 rtl/ldm_stm_pkg.sv | 19 +
 rtl/ldm_stm_sequencer_reg_list_scanner.sv | 29 ++
 rtl/ldm_stm_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_ldm_stm_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ldm_stm_pkg.sv
// Shared types and constants for the LDM/STM block-transfer sequencer.
// Optional feature macro: LDM_STM_WRITEBACK_EN (enables the base writeback state).
package ldm_stm_pkg;

    localparam int unsigned LIST_WIDTH     = 16;
    localparam int unsigned REG_ADDR_WIDTH = 4;
    localparam int unsigned COUNT_WIDTH    = $clog2(LIST_WIDTH + 1);
    localparam int unsigned WORD_BYTES     = 4;
    localparam int unsigned PC_INDEX       = 15;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        XFER  = 3'd2,
        WB    = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/ldm_stm_sequencer_reg_list_scanner.sv
// reg_list_scanner: combinational lowest-set-bit finder and popcount over a
// 16-bit register list.
//   i_list      : register list (bit k = Rk)
//   o_index_c   : index of the lowest set bit (0 when list is empty)
//   o_valid_c   : list is non-empty
//   o_count_c   : number of set bits
module reg_list_scanner
    import ldm_stm_pkg::*;
(
    input  logic [LIST_WIDTH-1:0]     i_list,
    output logic [REG_ADDR_WIDTH-1:0] o_index_c,
    output logic                      o_valid_c,
    output logic [COUNT_WIDTH-1:0]    o_count_c
);

    // Scan high to low so the last hit is the lowest set bit.
    always_comb begin
        o_index_c = '0;
        o_count_c = '0;
        for (int k = LIST_WIDTH - 1; k >= 0; k--) begin
            if (i_list[k]) begin
                o_index_c = REG_ADDR_WIDTH'(k);
            end
            o_count_c = o_count_c + COUNT_WIDTH'(i_list[k]);
        end
        o_valid_c = |i_list;
    end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// ldm_stm_sequencer: multi-cycle controller for ARMv7 LDM/STM (IA/IB/DA/DB).
// Steps through the latched register list lowest-first, issuing one memory
// access per register and driving the register-file read (STM) or write (LDM)
// port; r15 loads go to the PC port.
// Optional macro LDM_STM_WRITEBACK_EN: when defined, the W bit is honoured in a
// WB state; when undefined, i_Writeback is ignored and XFER goes straight to DONE.
// Ports:
//   clk, reset (async, active-high)
//   i_Start/i_Load/i_Register_List/i_Base_Register/i_Base_Address/
//   i_Increment/i_Before/i_Writeback : instruction request, latched in IDLE
//   o_Read_Address/i_Read_Data       : register-file read port (STM source)
//   o_Write_Enable/Address/Data      : register-file write port (r0-r14)
//   o_PC_Write/o_PC_Data             : LDM load into r15
//   o_Mem_* / i_Mem_*                : data-memory request/ready handshake
//   o_Busy, o_Done                   : core stall and completion pulse
// Register-file and memory data paths are combinational so an LDM write
// commits on the same edge as the memory accept.
module ldm_stm_sequencer
    import ldm_stm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_Start,
    input  logic                      i_Load,
    input  logic [LIST_WIDTH-1:0]     i_Register_List,
    input  logic [REG_ADDR_WIDTH-1:0] i_Base_Register,
    input  logic [DATA_WIDTH-1:0]     i_Base_Address,
    input  logic                      i_Increment,
    input  logic                      i_Before,
    input  logic                      i_Writeback,
    output logic [REG_ADDR_WIDTH-1:0] o_Read_Address,
    input  logic [DATA_WIDTH-1:0]     i_Read_Data,
    output logic                      o_Write_Enable,
    output logic [REG_ADDR_WIDTH-1:0] o_Write_Address,
    output logic [DATA_WIDTH-1:0]     o_Write_Data,
    output logic                      o_PC_Write,
    output logic [DATA_WIDTH-1:0]     o_PC_Data,
    output logic                      o_Mem_Request,
    output logic                      o_Mem_Write,
    output logic [DATA_WIDTH-1:0]     o_Mem_Address,
    output logic [DATA_WIDTH-1:0]     o_Mem_Write_Data,
    input  logic                      i_Mem_Ready,
    input  logic [DATA_WIDTH-1:0]     i_Mem_Read_Data,
    output logic                      o_Busy,
    output logic                      o_Done
);

    state_t                    state_q, state_d;
    logic [LIST_WIDTH-1:0]     list_q, list_d;
    logic                      load_q, load_d;
    logic [REG_ADDR_WIDTH-1:0] base_reg_q, base_reg_d;
    logic [DATA_WIDTH-1:0]     base_q, base_d;
    logic                      inc_q, inc_d;
    logic                      before_q, before_d;
    logic                      wb_q, wb_d;
    logic                      rn_in_list_q, rn_in_list_d;
    logic [DATA_WIDTH-1:0]     addr_q, addr_d;
    logic [DATA_WIDTH-1:0]     new_base_q, new_base_d;

    logic [REG_ADDR_WIDTH-1:0] scan_idx;
    logic                      scan_valid;
    logic [COUNT_WIDTH-1:0]    scan_count;
    logic [DATA_WIDTH-1:0]     span_c;

    // One scanner serves both the SETUP popcount and the per-transfer pick.
    reg_list_scanner u_scanner (
        .i_list    (list_q),
        .o_index_c (scan_idx),
        .o_valid_c (scan_valid),
        .o_count_c (scan_count)
    );

    always_comb span_c = DATA_WIDTH'(scan_count) * DATA_WIDTH'(WORD_BYTES);

    // State and latched-request registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            list_q       <= '0;
            load_q       <= 1'b0;
            base_reg_q   <= '0;
            base_q       <= '0;
            inc_q        <= 1'b0;
            before_q     <= 1'b0;
            wb_q         <= 1'b0;
            rn_in_list_q <= 1'b0;
            addr_q       <= '0;
            new_base_q   <= '0;
        end else begin
            state_q      <= state_d;
            list_q       <= list_d;
            load_q       <= load_d;
            base_reg_q   <= base_reg_d;
            base_q       <= base_d;
            inc_q        <= inc_d;
            before_q     <= before_d;
            wb_q         <= wb_d;
            rn_in_list_q <= rn_in_list_d;
            addr_q       <= addr_d;
            new_base_q   <= new_base_d;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d          = state_q;
        list_d           = list_q;
        load_d           = load_q;
        base_reg_d       = base_reg_q;
        base_d           = base_q;
        inc_d            = inc_q;
        before_d         = before_q;
        wb_d             = wb_q;
        rn_in_list_d     = rn_in_list_q;
        addr_d           = addr_q;
        new_base_d       = new_base_q;
        o_Read_Address   = '0;
        o_Write_Enable   = 1'b0;
        o_Write_Address  = '0;
        o_Write_Data     = '0;
        o_PC_Write       = 1'b0;
        o_PC_Data        = '0;
        o_Mem_Request    = 1'b0;
        o_Mem_Write      = 1'b0;
        o_Mem_Address    = '0;
        o_Mem_Write_Data = '0;
        o_Busy           = (state_q != IDLE);
        o_Done           = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (i_Start) begin
                    list_d       = i_Register_List;
                    load_d       = i_Load;
                    base_reg_d   = i_Base_Register;
                    base_d       = i_Base_Address;
                    inc_d        = i_Increment;
                    before_d     = i_Before;
                    wb_d         = i_Writeback;
                    rn_in_list_d = i_Register_List[i_Base_Register];
                    state_d      = SETUP;
                end
            end
            SETUP: begin
                // Lowest register always maps to the lowest address.
                if (inc_q) begin
                    addr_d     = before_q ? base_q + DATA_WIDTH'(WORD_BYTES) : base_q;
                    new_base_d = base_q + span_c;
                end else begin
                    addr_d     = before_q ? base_q - span_c
                                          : base_q - span_c + DATA_WIDTH'(WORD_BYTES);
                    new_base_d = base_q - span_c;
                end
                state_d = scan_valid ? XFER : DONE;
            end
            XFER: begin
                o_Mem_Request = 1'b1;
                o_Mem_Write   = ~load_q;
                o_Mem_Address = addr_q;
                if (!load_q) begin
                    o_Read_Address   = scan_idx;
                    o_Mem_Write_Data = i_Read_Data;
                end
                if (i_Mem_Ready) begin
                    if (load_q) begin
                        if (scan_idx == REG_ADDR_WIDTH'(PC_INDEX)) begin
                            o_PC_Write = 1'b1;
                            o_PC_Data  = i_Mem_Read_Data;
                        end else begin
                            o_Write_Enable  = 1'b1;
                            o_Write_Address = scan_idx;
                            o_Write_Data    = i_Mem_Read_Data;
                        end
                    end
                    list_d = list_q & ~(LIST_WIDTH'(1) << scan_idx);
                    addr_d = addr_q + DATA_WIDTH'(WORD_BYTES);
                    if (scan_count == COUNT_WIDTH'(1)) begin
`ifdef LDM_STM_WRITEBACK_EN
                        state_d = WB;
`else
                        state_d = DONE;
`endif
                    end
                end
            end
            WB: begin
`ifdef LDM_STM_WRITEBACK_EN
                // A loaded Rn wins over the updated base; r15 is never a target here.
                if (wb_q && !(load_q && rn_in_list_q) &&
                    (base_reg_q != REG_ADDR_WIDTH'(PC_INDEX))) begin
                    o_Write_Enable  = 1'b1;
                    o_Write_Address = base_reg_q;
                    o_Write_Data    = new_base_q;
                end
`endif
                state_d = DONE;
            end
            DONE: begin
                o_Done  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifndef LDM_STM_WRITEBACK_EN
    // Writeback bookkeeping has no consumer without the WB state.
    logic unused_wb;
    assign unused_wb = ^{wb_q, base_reg_q, new_base_q, rn_in_list_q};
`endif

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Self-checking bench for ldm_stm_sequencer: directed vector table, a reset
// abort sequence and randomized operations against a behavioural model.
module tb_ldm_stm_sequencer;

`ifdef LDM_STM_WRITEBACK_EN
    localparam bit WB_EN = 1'b1;
`else
    localparam bit WB_EN = 1'b0;
`endif
    localparam logic [31:0] PC_VAL = 32'h0000_8008;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_Start, i_Load, i_Increment, i_Before, i_Writeback;
    logic [15:0] i_Register_List;
    logic [3:0]  i_Base_Register;
    logic [31:0] i_Base_Address;
    logic [3:0]  o_Read_Address;
    logic [31:0] i_Read_Data;
    logic        o_Write_Enable;
    logic [3:0]  o_Write_Address;
    logic [31:0] o_Write_Data;
    logic        o_PC_Write;
    logic [31:0] o_PC_Data;
    logic        o_Mem_Request, o_Mem_Write;
    logic [31:0] o_Mem_Address, o_Mem_Write_Data;
    logic        i_Mem_Ready;
    logic [31:0] i_Mem_Read_Data;
    logic        o_Busy, o_Done;

    logic [31:0] rf [16];
    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    always #5 clk = ~clk;

    assign i_Read_Data     = (o_Read_Address == 4'd15) ? PC_VAL : rf[o_Read_Address];
    assign i_Mem_Read_Data = mem_rd(o_Mem_Address);

    ldm_stm_sequencer #(.DATA_WIDTH(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .i_Start          (i_Start),
        .i_Load           (i_Load),
        .i_Register_List  (i_Register_List),
        .i_Base_Register  (i_Base_Register),
        .i_Base_Address   (i_Base_Address),
        .i_Increment      (i_Increment),
        .i_Before         (i_Before),
        .i_Writeback      (i_Writeback),
        .o_Read_Address   (o_Read_Address),
        .i_Read_Data      (i_Read_Data),
        .o_Write_Enable   (o_Write_Enable),
        .o_Write_Address  (o_Write_Address),
        .o_Write_Data     (o_Write_Data),
        .o_PC_Write       (o_PC_Write),
        .o_PC_Data        (o_PC_Data),
        .o_Mem_Request    (o_Mem_Request),
        .o_Mem_Write      (o_Mem_Write),
        .o_Mem_Address    (o_Mem_Address),
        .o_Mem_Write_Data (o_Mem_Write_Data),
        .i_Mem_Ready      (i_Mem_Ready),
        .i_Mem_Read_Data  (i_Mem_Read_Data),
        .o_Busy           (o_Busy),
        .o_Done           (o_Done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one instruction (called 1 time unit after a rising edge) and follow
    // it to completion, checking every cycle against the architectural model.
    task automatic run_op(input logic load, input logic [15:0] list, input logic [3:0] rn,
                          input logic [31:0] base, input logic u, input logic p,
                          input logic w, input int stall, input bit rnd,
                          output int done_cyc, output logic [31:0] first_addr,
                          output logic [31:0] wb_val);
        int          n, idx, cyc, stalls, wb_seen, exp_done;
        logic [31:0] four_n, lo, new_base, exp_addr, exp_sd;
        logic [31:0] snap [16];
        logic [3:0]  regs [$];
        logic        exp_wb, pend_we;
        logic [3:0]  pend_a;
        logic [31:0] pend_d;

        rf[rn] = base;
        for (int i = 0; i < 16; i++) begin
            snap[i] = rf[i];
            if (list[i]) regs.push_back(4'(i));
        end
        n        = regs.size();
        four_n   = 32'(n) * 32'd4;
        lo       = u ? (p ? base + 32'd4 : base) : (p ? base - four_n : base - four_n + 32'd4);
        new_base = u ? base + four_n : base - four_n;
        exp_wb   = WB_EN && w && (n > 0) && !(load && list[rn]) && (rn != 4'd15);

        i_Start = 1'b1; i_Load = load; i_Register_List = list; i_Base_Register = rn;
        i_Base_Address = base; i_Increment = u; i_Before = p; i_Writeback = w;
        @(posedge clk); #1;
        // Scramble request inputs: the sequencer must have latched them.
        i_Start = 1'b0; i_Load = ~load; i_Register_List = 16'($urandom);
        i_Base_Register = 4'($urandom); i_Base_Address = $urandom;
        i_Increment = ~u; i_Before = ~p; i_Writeback = ~w;

        cyc = 0; idx = 0; stalls = 0; wb_seen = 0; done_cyc = -1;
        first_addr = '0; wb_val = '0;
        while (done_cyc < 0 && cyc < 300) begin
            cyc++;
            i_Mem_Ready = rnd ? ($urandom_range(0, 2) != 0) : (cyc >= stall + 2);
            if (rnd) i_Start = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            pend_we = 1'b0; pend_a = '0; pend_d = '0;
            check("busy", 32'(o_Busy), 32'd1);
            check("request", 32'(o_Mem_Request), 32'((cyc >= 2) && (idx < n)));
            if (o_Mem_Request && idx < n) begin
                exp_addr = lo + 32'(idx) * 32'd4;
                check("mem_addr", o_Mem_Address, exp_addr);
                check("mem_write", 32'(o_Mem_Write), 32'(!load));
                if (!load) begin
                    exp_sd = (regs[idx] == 4'd15) ? PC_VAL : snap[regs[idx]];
                    check("store_data", o_Mem_Write_Data, exp_sd);
                end
                if (i_Mem_Ready) begin
                    if (idx == 0) first_addr = o_Mem_Address;
                    if (load && regs[idx] == 4'd15) begin
                        check("pc_write", 32'({o_PC_Write, o_Write_Enable}), 32'd2);
                        check("pc_data", o_PC_Data, mem_rd(exp_addr));
                    end else if (load) begin
                        check("ld_we", 32'({o_Write_Enable, o_PC_Write}), 32'd2);
                        check("ld_waddr", 32'(o_Write_Address), 32'(regs[idx]));
                        check("ld_wdata", o_Write_Data, mem_rd(exp_addr));
                    end else begin
                        check("st_no_write", 32'({o_Write_Enable, o_PC_Write}), 32'd0);
                    end
                    idx++;
                end else begin
                    stalls++;
                    check("stall_no_write", 32'({o_Write_Enable, o_PC_Write}), 32'd0);
                end
            end else begin
                check("pc_write_idle", 32'(o_PC_Write), 32'd0);
                if (o_Write_Enable) begin
                    wb_seen++;
                    wb_val = o_Write_Data;
                    check("wb_addr", 32'(o_Write_Address), 32'(rn));
                    check("wb_data", o_Write_Data, new_base);
                end
            end
            if (o_Write_Enable) begin
                pend_we = 1'b1; pend_a = o_Write_Address; pend_d = o_Write_Data;
            end
            if (o_Done) done_cyc = cyc;
            @(posedge clk);
            if (pend_we) rf[pend_a] = pend_d;
            #1;
        end
        i_Start = 1'b0;
        exp_done = (n == 0) ? 2 : n + stalls + 1 + (WB_EN ? 2 : 1);
        check("done_cycle", 32'(done_cyc), 32'(exp_done));
        check("accepts", 32'(idx), 32'(n));
        check("wb_count", 32'(wb_seen), 32'(exp_wb));
        check("back_idle", 32'({o_Busy, o_Done, o_Mem_Request}), 32'd0);
    endtask

    typedef struct {
        logic        load;
        logic [15:0] list;
        logic [3:0]  rn;
        logic [31:0] base;
        logic        u, p, w;
        int          stall;
        int          done_wb;
        int          done_nowb;
        logic [31:0] first;
        logic [31:0] wb_val;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs [NV];

    initial begin
        int          dc;
        logic [31:0] fa, wv;
        logic [15:0] rl;
        logic [31:0] rb;

        reset = 1'b1; i_Start = 1'b0; i_Load = 1'b0; i_Register_List = '0;
        i_Base_Register = '0; i_Base_Address = '0; i_Increment = 1'b0;
        i_Before = 1'b0; i_Writeback = 1'b0; i_Mem_Ready = 1'b0;
        for (int i = 0; i < 16; i++) rf[i] = 32'h1000_0000 + 32'(i) * 32'h11;

        // load, list, rn, base, U, P, W, stall, done(WB), done(no WB), first addr, WB value
        vecs[0] = '{1'b1, 16'h0016, 4'd0,  32'h100,  1'b1, 1'b0, 1'b1, 0, 6, 5, 32'h100,  32'h10C};
        vecs[1] = '{1'b0, 16'h4010, 4'd13, 32'h200,  1'b0, 1'b1, 1'b1, 0, 5, 4, 32'h1F8,  32'h1F8};
        vecs[2] = '{1'b0, 16'h0001, 4'd1,  32'h40,   1'b1, 1'b1, 1'b0, 3, 7, 6, 32'h44,   32'h0};
        vecs[3] = '{1'b1, 16'h8004, 4'd2,  32'h300,  1'b0, 1'b0, 1'b1, 0, 5, 4, 32'h2FC,  32'h0};
        vecs[4] = '{1'b1, 16'h0000, 4'd3,  32'h500,  1'b1, 1'b0, 1'b1, 0, 2, 2, 32'h0,    32'h0};
        vecs[5] = '{1'b1, 16'h0021, 4'd3,  32'h1000, 1'b0, 1'b1, 1'b1, 1, 6, 5, 32'hFF8,  32'hFF8};
        vecs[6] = '{1'b0, 16'h8020, 4'd5,  32'h80,   1'b0, 1'b0, 1'b1, 0, 5, 4, 32'h7C,   32'h78};

        repeat (3) @(posedge clk);
        #1;
        check("rst_ctrl", 32'({o_Busy, o_Done, o_Mem_Request, o_Mem_Write,
                               o_Write_Enable, o_PC_Write}), 32'd0);
        check("rst_addr", o_Mem_Address, 32'd0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;

        // Directed vector table.
        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].load, vecs[i].list, vecs[i].rn, vecs[i].base, vecs[i].u,
                   vecs[i].p, vecs[i].w, vecs[i].stall, 1'b0, dc, fa, wv);
            check($sformatf("vec%0d_done", i), 32'(dc),
                  32'(WB_EN ? vecs[i].done_wb : vecs[i].done_nowb));
            check($sformatf("vec%0d_first", i), fa, vecs[i].first);
            check($sformatf("vec%0d_wbval", i), wv, WB_EN ? vecs[i].wb_val : 32'h0);
            if (i == 3) check("ldmda_r2_loaded", rf[2], mem_rd(32'h2FC));
        end

        // Reset during the second transfer of a 4-register LDM.
        rf[1] = 32'hDEAD_0001;
        i_Start = 1'b1; i_Load = 1'b1; i_Register_List = 16'h00AA; i_Base_Register = 4'd0;
        i_Base_Address = 32'h500; i_Increment = 1'b1; i_Before = 1'b0; i_Writeback = 1'b1;
        i_Mem_Ready = 1'b1;
        @(posedge clk); #1;
        i_Start = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("abort_first_we", 32'({o_Write_Enable, o_Write_Address}), 32'h11);
        check("abort_first_data", o_Write_Data, mem_rd(32'h500));
        if (o_Write_Enable) rf[o_Write_Address] = o_Write_Data;
        @(posedge clk); #1;
        check("abort_second_addr", o_Mem_Address, 32'h504);
        reset = 1'b1;
        #1;
        check("abort_ctrl", 32'({o_Busy, o_Done, o_Mem_Request, o_Mem_Write,
                                 o_Write_Enable, o_PC_Write}), 32'd0);
        check("abort_addr", o_Mem_Address, 32'd0);
        @(negedge clk) reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("abort_quiet", 32'({o_Busy, o_Mem_Request, o_Write_Enable, o_PC_Write}), 32'd0);
        end
        check("abort_r1_kept", rf[1], mem_rd(32'h500));
        @(posedge clk); #1;
        run_op(1'b1, 16'h00AA, 4'd0, 32'h500, 1'b1, 1'b0, 1'b1, 0, 1'b0, dc, fa, wv);
        check("restart_done", 32'(dc), 32'(WB_EN ? 7 : 6));

        // Randomized operations with random wait states and stray starts.
        for (int t = 0; t < 40; t++) begin
            rl = 16'($urandom);
            if ($urandom_range(0, 7) == 0) rl = '0;
            else if ($urandom_range(0, 1) == 0) rl = rl & 16'($urandom);
            rb = $urandom & 32'hFFFF_FFFC;
            run_op(1'($urandom), rl, 4'($urandom), rb, 1'($urandom), 1'($urandom),
                   1'($urandom), 0, 1'b1, dc, fa, wv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
